// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch: FSM states, BCD time,
// active-low seven-segment patterns and the BCD increment helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } bcd_time_t;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] BCD_ONES_MAX = 4'd9;
    localparam logic [3:0] BCD_TENS_MAX = 4'd5;

    // One-second step; wraps to 00:00 after max_tens max_ones : 59
    function automatic bcd_time_t bcd_step(input bcd_time_t t,
                                           input logic [3:0] max_tens,
                                           input logic [3:0] max_ones);
        bcd_time_t n;
        n = t;
        if (t.sec_ones != BCD_ONES_MAX) begin
            n.sec_ones = t.sec_ones + 4'd1;
        end else begin
            n.sec_ones = '0;
            if (t.sec_tens != BCD_TENS_MAX) begin
                n.sec_tens = t.sec_tens + 4'd1;
            end else begin
                n.sec_tens = '0;
                if (t.min_tens == max_tens && t.min_ones == max_ones) begin
                    n.min_tens = '0;
                    n.min_ones = '0;
                end else if (t.min_ones == BCD_ONES_MAX) begin
                    n.min_ones = '0;
                    n.min_tens = t.min_tens + 4'd1;
                end else begin
                    n.min_ones = t.min_ones + 4'd1;
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_seg7.sv
// BCD to active-low seven-segment decoder; codes 10-15 blank the digit.
module seg7_decoder
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch stepping once per slow_clk rising edge, all in the clk domain.
// Optional lap-hold display freeze is compiled in with STOPWATCH_LAP_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN = 59
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       slow_clk,
    input  logic       start_stop_p,
    input  logic       clear_p,
    input  logic       lap_p,
    output logic       running,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3
);

    localparam logic [3:0] MAX_TENS = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_ONES = 4'(MAX_MIN % 10);

    logic      s1, s2, s3;
    logic      tick;
    state_t    state_q, state_d;
    bcd_time_t count_q;
    bcd_time_t shown;

    // s3 holds the previous synchronised level so only rising edges tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= slow_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick = s2 & ~s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear_p) begin
            state_d = IDLE;
        end else if (start_stop_p) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    assign running = (state_q == RUN);

    // A tick arriving with the pause pulse still counts because RUN is the current state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear_p) begin
            count_q <= '0;
        end else if (state_q == RUN && tick) begin
            count_q <= bcd_step(count_q, MAX_TENS, MAX_ONES);
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic      lap_hold;
    bcd_time_t lap_snap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_hold <= 1'b0;
            lap_snap <= '0;
        end else if (clear_p) begin
            lap_hold <= 1'b0;
        end else if (lap_p) begin
            lap_hold <= ~lap_hold;
            if (!lap_hold) lap_snap <= count_q;
        end
    end

    assign shown = lap_hold ? lap_snap : count_q;
`else
    logic unused_lap;
    assign unused_lap = lap_p;
    assign shown      = count_q;
`endif

    assign sec_ones = shown.sec_ones;
    assign sec_tens = shown.sec_tens;
    assign min_ones = shown.min_ones;
    assign min_tens = shown.min_tens;

    seg7_decoder u_hex0 (.bcd(shown.sec_ones), .seg(hex0));
    seg7_decoder u_hex1 (.bcd(shown.sec_tens), .seg(hex1));
    seg7_decoder u_hex2 (.bcd(shown.min_ones), .seg(hex2));
    seg7_decoder u_hex3 (.bcd(shown.min_tens), .seg(hex3));

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl (MAX_MIN=1 so wrap is reachable quickly);
// lap checks follow STOPWATCH_LAP_EN.
module tb_stopwatch_ctrl;

    localparam int TB_MAX_MIN = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       slow_clk;
    logic       start_stop_p;
    logic       clear_p;
    logic       lap_p;
    logic       running;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic [6:0] hex0, hex1, hex2, hex3;

    typedef struct {
        int          due;
        string       name;
        logic [15:0] bcd;
        logic        run;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    stopwatch_ctrl #(.MAX_MIN(TB_MAX_MIN)) dut (
        .clk(clk),
        .reset(reset),
        .slow_clk(slow_clk),
        .start_stop_p(start_stop_p),
        .clear_p(clear_p),
        .lap_p(lap_p),
        .running(running),
        .sec_ones(sec_ones),
        .sec_tens(sec_tens),
        .min_ones(min_ones),
        .min_tens(min_tens),
        .hex0(hex0),
        .hex1(hex1),
        .hex2(hex2),
        .hex3(hex3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic exp_t mk(input string n, input logic [15:0] bcd, input logic run);
        exp_t e;
        e.due  = 0;
        e.name = n;
        e.bcd  = bcd;
        e.run  = run;
        return e;
    endfunction

    // Expected BCD is written as hex nibbles MM:SS, e.g. 16'h0105 is 01:05
    task automatic checkOutput(input exp_t e, input int delay);
        e.due = cyc + delay;
        sb.push_back(e);
    endtask

    // Monitor: samples 1 time unit after each rising edge
    always begin
        exp_t        e;
        logic [15:0] got_bcd;
        logic [27:0] got_hex, exp_hex;
        @(posedge clk);
        #1;
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            e       = sb.pop_front();
            got_bcd = {min_tens, min_ones, sec_tens, sec_ones};
            got_hex = {hex3, hex2, hex1, hex0};
            exp_hex = {seg_of(e.bcd[15:12]), seg_of(e.bcd[11:8]),
                       seg_of(e.bcd[7:4]), seg_of(e.bcd[3:0])};
            checks++;
            if (e.due != cyc || got_bcd !== e.bcd || got_hex !== exp_hex || running !== e.run) begin
                errors++;
                $display("[TB] FAIL %s: got %h%h:%h%h hex=%h run=%b, expected %h%h:%h%h hex=%h run=%b (cycle %0d due %0d)",
                         e.name, min_tens, min_ones, sec_tens, sec_ones, got_hex, running,
                         e.bcd[15:12], e.bcd[11:8], e.bcd[7:4], e.bcd[3:0], exp_hex, e.run,
                         cyc, e.due);
            end
        end
    end

    // One slow_clk rising edge; coinc {lap,clear,start_stop} is driven in the tick cycle
    task automatic slow_edge(input logic [2:0] coinc, input bit do_chk, input exp_t ce);
        @(negedge clk);
        slow_clk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        {lap_p, clear_p, start_stop_p} = coinc;
        if (do_chk) checkOutput(ce, 1);
        @(negedge clk);
        {lap_p, clear_p, start_stop_p} = 3'b000;
        @(negedge clk);
        slow_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic applyStimulus(input int n_edges);
        for (int i = 0; i < n_edges; i++) slow_edge(3'b000, 1'b0, mk("", 16'h0000, 1'b0));
    endtask

    task automatic pulse(input logic [2:0] p, input exp_t e);
        @(negedge clk);
        {lap_p, clear_p, start_stop_p} = p;
        checkOutput(e, 1);
        @(negedge clk);
        {lap_p, clear_p, start_stop_p} = 3'b000;
    endtask

    initial begin
        reset = 1'b1;
        slow_clk = 1'b0;
        start_stop_p = 1'b0;
        clear_p = 1'b0;
        lap_p = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput(mk("reset_hold", 16'h0000, 1'b0), 1);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(5);
        checkOutput(mk("idle_no_count", 16'h0000, 1'b0), 1);

        pulse(3'b001, mk("start", 16'h0000, 1'b1));
        @(negedge clk);
        slow_clk = 1'b1;
        checkOutput(mk("latency_before", 16'h0000, 1'b1), 2);
        checkOutput(mk("latency_after", 16'h0001, 1'b1), 3);
        repeat (4) @(negedge clk);
        slow_clk = 1'b0;
        repeat (4) @(negedge clk);
        applyStimulus(58);
        checkOutput(mk("count_59", 16'h0059, 1'b1), 1);
        applyStimulus(1);
        checkOutput(mk("minute_carry", 16'h0100, 1'b1), 1);
        applyStimulus(1);
        checkOutput(mk("count_61", 16'h0101, 1'b1), 1);

        pulse(3'b010, mk("clear", 16'h0000, 1'b0));
        pulse(3'b001, mk("restart", 16'h0000, 1'b1));
        applyStimulus(7);
        checkOutput(mk("count_7", 16'h0007, 1'b1), 1);
        applyStimulus(1);
        checkOutput(mk("count_8", 16'h0008, 1'b1), 1);
        applyStimulus(1);
        checkOutput(mk("count_9", 16'h0009, 1'b1), 1);
        slow_edge(3'b001, 1'b1, mk("pause_with_tick", 16'h0010, 1'b0));
        applyStimulus(5);
        checkOutput(mk("paused_hold", 16'h0010, 1'b0), 1);
        slow_edge(3'b001, 1'b1, mk("resume_with_tick", 16'h0010, 1'b1));
        applyStimulus(3);
        checkOutput(mk("resumed_13", 16'h0013, 1'b1), 1);

        applyStimulus(29);
        checkOutput(mk("count_42", 16'h0042, 1'b1), 1);
        slow_edge(3'b011, 1'b1, mk("clear_priority", 16'h0000, 1'b0));
        applyStimulus(2);
        checkOutput(mk("idle_after_clear", 16'h0000, 1'b0), 1);

        pulse(3'b001, mk("start_wrap", 16'h0000, 1'b1));
        applyStimulus(6);
        checkOutput(mk("count_6", 16'h0006, 1'b1), 1);
        applyStimulus(113);
        checkOutput(mk("max_value", 16'h0159, 1'b1), 1);
        applyStimulus(1);
        checkOutput(mk("wrap", 16'h0000, 1'b1), 1);
        applyStimulus(3);
        checkOutput(mk("after_wrap", 16'h0003, 1'b1), 1);

        @(negedge clk);
        #2;
        reset = 1'b1;
        checkOutput(mk("async_reset", 16'h0000, 1'b0), 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pulse(3'b001, mk("start_after_reset", 16'h0000, 1'b1));
        applyStimulus(5);
        checkOutput(mk("count_5", 16'h0005, 1'b1), 1);

`ifdef STOPWATCH_LAP_EN
        pulse(3'b100, mk("lap_hold", 16'h0005, 1'b1));
        applyStimulus(4);
        checkOutput(mk("lap_frozen", 16'h0005, 1'b1), 1);
        pulse(3'b100, mk("lap_release", 16'h0009, 1'b1));
        pulse(3'b100, mk("lap_hold2", 16'h0009, 1'b1));
        applyStimulus(1);
        checkOutput(mk("lap_frozen2", 16'h0009, 1'b1), 1);
`else
        pulse(3'b100, mk("lap_ignored", 16'h0005, 1'b1));
        applyStimulus(4);
        checkOutput(mk("lap_live", 16'h0009, 1'b1), 1);
        pulse(3'b100, mk("lap_ignored2", 16'h0009, 1'b1));
        pulse(3'b100, mk("lap_ignored3", 16'h0009, 1'b1));
        applyStimulus(1);
        checkOutput(mk("lap_live2", 16'h0010, 1'b1), 1);
`endif
        pulse(3'b010, mk("clear_final", 16'h0000, 1'b0));
        pulse(3'b001, mk("start_final", 16'h0000, 1'b1));
        applyStimulus(2);
        checkOutput(mk("live_after_clear", 16'h0002, 1'b1), 1);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d expectations still pending, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

MM:SS stopwatch that consumes the slow square wave from the system clock divider and counts one step per slow-clock rising edge. Sits directly downstream of the divider on the DE2-115 build. Keeps all logic in the 50 MHz `clk` domain by synchronising the slow clock and edge-detecting it. Drives four active-low seven-segment displays.

## Interface
- `MAX_MIN`, default 59: last minute value before wrap; legal range 1..99.
- `clk`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-high.
- `slow_clk`  in  1  slow square wave from the divider; asynchronous to `clk`.
- `start_stop_p`  in  1  single-cycle pulse from the debouncer; toggles run/pause.
- `clear_p`  in  1  single-cycle pulse; returns to zero and IDLE.
- `lap_p`  in  1  single-cycle pulse; lap hold control, active only with the lap feature compiled in.
- `running`  out  1  high while in RUN.
- `sec_ones`, `sec_tens`, `min_ones`, `min_tens`  out  4 each  BCD of the displayed value.
- `hex0`..`hex3`  out  7 each  active-low segments {g,f,e,d,c,b,a}. `hex0` shows `sec_ones`; `hex3` shows `min_tens`.

## Operation
- **Tick generation**
  - `slow_clk` passes through a 2-FF synchroniser (`s1`, `s2`), then a history register `s3`.
  - `tick = s2 & ~s3`, high for exactly one `clk` cycle per slow-clock rising edge.
  - Falling edges are ignored.
- **FSM states: IDLE, RUN, PAUSE**
  - IDLE + `start_stop_p` -> RUN.
  - RUN + `start_stop_p` -> PAUSE.
  - PAUSE + `start_stop_p` -> RUN.
  - `clear_p` in any state -> IDLE, and the count is zeroed.
- **Counting:** on `tick` while in RUN, the count increments.
  - Each digit counts in BCD.
  - `sec_ones` carries at 9 into `sec_tens`.
  - `sec_tens` carries at 5 into minutes.
  - Minutes are held as BCD tens/ones.
  - At MM = `MAX_MIN` and SS = 59, the count wraps to 00:00 and the FSM stays in RUN.
- **Simultaneous events**
  - `clear_p` has priority over everything else.
  - `tick` with `start_stop_p` while in RUN: the increment happens and the state goes to PAUSE.
  - `tick` with `start_stop_p` while in PAUSE: no increment and the state goes to RUN. The next tick counts.
- **Illegal input:** simultaneous `start_stop_p` and `clear_p` resolves to IDLE.
- **Segment decode:** combinational from the displayed BCD digits.
  - Values 0-9 use the standard patterns.
  - Values 10-15 blank the display (7'h7F).

## Timing
- **Reset values:**
  - state IDLE, all digits 0, `running` 0.
  - `s1`, `s2`, `s3` all 0.
  - `hex0`..`hex3` = 7'b1000000 ("0").
- **Tick latency**
  - Let E0 be the first `clk` edge sampling `slow_clk` high. `s2` rises at E1 and `tick` is high between E1 and E2.
  - The count updates at E2: 2 cycles after E0, plus up to 1 cycle of sampling uncertainty.
- **Control latency**
  - `start_stop_p` and `clear_p` take effect at the edge that samples them.
  - `running` reflects the new state in the following cycle.
- BCD and hex outputs change in the same cycle as the count registers; there is no extra pipeline stage.
- **Reset mid-operation:** returns to reset values immediately (asynchronous). The first tick after reset release requires a fresh rising edge of `s2`.
- The minimum `slow_clk` high and low time is 2 `clk` periods; faster input is unsupported.

## Configuration
- Macro: `STOPWATCH_LAP_EN`.
- **Defined:**
  - `lap_p` toggles a lap-hold flag.
  - While the flag is set, the BCD and hex outputs show a snapshot captured at the `lap_p` edge, while the internal count keeps running.
  - A second `lap_p` releases the hold and the outputs show the live count in the next cycle.
  - `clear_p` or `reset` also releases the hold.
- **Undefined:** `lap_p` is accepted and ignored; the outputs always show the live count.

## Structure
- Shared package `stopwatch_pkg`:
  - state encoding (IDLE=0, RUN=1, PAUSE=2, 2 bits).
  - segment constants `SEG_0`..`SEG_9` and `SEG_BLANK`.
  - BCD limit constants (9, 5).
- Sub-module `seg7_decoder` (4-bit BCD in, 7-bit active-low out), instantiated four times.
- Synchroniser, FSM, and BCD counter chain live in `stopwatch_ctrl`.

## Test plan
- **Reset and idle:** assert reset, release, toggle `slow_clk` 5 times without a start pulse -> digits stay 00:00, all hex = 7'h40, `running`=0.
- **Start and count:** pulse `start_stop_p`, apply 61 slow-clock rising edges -> display 01:01, `running`=1. Each update occurs 2 cycles after the synchronised edge.
- **Pause and resume:** after 10 counts pulse `start_stop_p`, apply 5 edges, then pulse again and apply 3 edges -> 00:13. The tick coincident with the pause pulse is counted.
- **Wrap:** with `MAX_MIN`=1, run 120 edges -> wraps to 00:00 and `running` stays 1.
- **Clear priority:** `clear_p`, `start_stop_p` and `tick` in the same cycle while in RUN at 00:42 -> next cycle 00:00, IDLE, `running`=0.
- **Lap** (`STOPWATCH_LAP_EN`): `lap_p` at 00:05, then 4 edges -> outputs stay 00:05. A second `lap_p` -> 00:09 next cycle.
